// File: rtl/traffic_timer_pkg.sv
// Shared types and default timing constants for the traffic-light controller and its interval timer.
package traffic_pkg;

   localparam int unsigned TRAFFIC_SHORT_TICKS = 3;
   localparam int unsigned TRAFFIC_LONG_TICKS  = 10;
   localparam int unsigned TRAFFIC_PRESCALE    = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } timer_state_t;

   typedef enum logic [1:0] {
      HWY_GREEN   = 2'd0,
      HWY_YELLOW  = 2'd1,
      FARM_GREEN  = 2'd2,
      FARM_YELLOW = 2'd3
   } light_state_t;

endpackage

// File: rtl/traffic_timer_if.sv
// Controller <-> timer signal bundle; the controller side is master, the timer side is slave.
interface traffic_timer_if;
   import traffic_pkg::*;

   // ST is a fire-and-forget start strobe: no ready, the timer accepts it on every edge it is high.
   // TS/TL/busy are registered levels, valid every cycle; state is the timer FSM for observation.
   logic         ST;
   logic         TS;
   logic         TL;
   logic         busy;
   timer_state_t state;

   modport master (output ST, input TS, input TL, input busy, input state);
   modport slave  (input ST, output TS, output TL, output busy, output state);

endinterface

// File: rtl/traffic_timer_tick_gen.sv
// Tick enable for the interval timer. TRAFFIC_TIMER_PRESCALE_EN adds a PRESCALE-clock
// prescaler; without it every clock is a tick.
module tick_gen
   import traffic_pkg::*;
`ifdef TRAFFIC_TIMER_PRESCALE_EN
#(
   parameter int unsigned PRESCALE = TRAFFIC_PRESCALE
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] pre_q;
   logic [PW-1:0] pre_d;

   assign tick = en && (pre_q == PW'(PRESCALE - 1));

   // clr wins so a restart always begins a full prescale period
   always_comb begin
      pre_d = pre_q;
      if (clr) begin
         pre_d = '0;
      end else if (en) begin
         pre_d = tick ? '0 : pre_q + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end
`else
(
   output logic tick
);

   assign tick = 1'b1;
`endif

endmodule

// File: rtl/traffic_timer.sv
// Interval timer: ST (re)starts counting, TS/TL flag the short and long intervals.
// Define TRAFFIC_TIMER_PRESCALE_EN to count prescaled ticks instead of clocks.
module traffic_timer
   import traffic_pkg::*;
#(
   parameter int unsigned SHORT_TICKS = TRAFFIC_SHORT_TICKS,
   parameter int unsigned LONG_TICKS  = TRAFFIC_LONG_TICKS,
   parameter int unsigned PRESCALE    = TRAFFIC_PRESCALE
) (
   input  logic            Clk,
   input  logic            reset,
   traffic_timer_if.slave  tif
);

   localparam int unsigned CW = $clog2(LONG_TICKS + 1);

   timer_state_t  state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          ts_q, ts_d;
   logic          tl_q, tl_d;
   logic          tick;

`ifdef TRAFFIC_TIMER_PRESCALE_EN
   tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clk  (Clk),
      .rst  (reset),
      .clr  (tif.ST),
      .en   (state_q == RUN),
      .tick (tick)
   );
`else
   tick_gen u_tick_gen (
      .tick (tick)
   );
`endif

   // ST outranks a coincident tick; DONE freezes count and flags until the next ST
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      ts_d    = ts_q;
      tl_d    = tl_q;
      if (tif.ST) begin
         state_d = RUN;
         count_d = '0;
         ts_d    = 1'b0;
         tl_d    = 1'b0;
      end else if (state_q == RUN && tick) begin
         count_d = count_q + CW'(1);
         if (count_d == CW'(SHORT_TICKS)) begin
            ts_d = 1'b1;
         end
         if (count_d == CW'(LONG_TICKS)) begin
            tl_d    = 1'b1;
            state_d = DONE;
         end
      end
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         ts_q    <= 1'b0;
         tl_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ts_q    <= ts_d;
         tl_q    <= tl_d;
      end
   end

   assign tif.TS    = ts_q;
   assign tif.TL    = tl_q;
   assign tif.busy  = (state_q == RUN);
   assign tif.state = state_q;

endmodule

// File: tb/tb_traffic_timer.sv
// Scoreboard bench for traffic_timer: a clock-count reference model feeds an expected queue
// that a negedge monitor drains against TS/TL/busy.
module tb_traffic_timer;

   localparam int SHORT = 3;
   localparam int LONG  = 10;
   localparam int PRE   = 4;
`ifdef TRAFFIC_TIMER_PRESCALE_EN
   localparam int TICK_CLKS = PRE;
`else
   localparam int TICK_CLKS = 1;
`endif

   logic clk = 1'b0;
   logic reset;

   traffic_timer_if tif ();

   traffic_timer #(
      .SHORT_TICKS (SHORT),
      .LONG_TICKS  (LONG),
      .PRESCALE    (PRE)
   ) dut (
      .Clk   (clk),
      .reset (reset),
      .tif   (tif)
   );

   always #5 clk = ~clk;

   // reference model: clocks elapsed since the last accepted start
   bit    started = 1'b0;
   int    elapsed = 0;
   string phase   = "init";

   logic [2:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [2:0] model_out(bit s, int e);
      int  ticks;
      logic ts, tl, busy;
      ticks = e / TICK_CLKS;
      ts    = s && (ticks >= SHORT);
      tl    = s && (ticks >= LONG);
      busy  = s && !tl;
      return {ts, tl, busy};
   endfunction

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: TS/TL/busy got %b expected %b", name, $time, act, exp);
      end
   endtask

   // drive ST for one edge, then advance the model to match that edge
   task automatic step(input logic st);
      tif.ST = st;
      @(posedge clk);
      #1;
      if (reset) begin
         started = 1'b0;
         elapsed = 0;
      end else if (st) begin
         started = 1'b1;
         elapsed = 0;
      end else if (started && elapsed < 100000) begin
         elapsed++;
      end
      exp_q.push_back(model_out(started, elapsed));
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [2:0] e;
         e = exp_q.pop_front();
         check(phase, {tif.TS, tif.TL, tif.busy}, e);
      end
   end

   initial begin
      tif.ST = 1'b0;
      reset  = 1'b1;
      #2;
      check("reset_state", {tif.TS, tif.TL, tif.busy}, 3'b000);
      phase = "in_reset";
      idle_steps(2);
      #1 reset = 1'b0;

      phase = "idle_no_st";
      idle_steps(20);

      phase = "single_st";
      step(1'b1);
      idle_steps(LONG * TICK_CLKS + 10);

      phase = "restart_mid";
      step(1'b1);
      idle_steps(4);
      step(1'b1);
      idle_steps(LONG * TICK_CLKS + 5);

      phase = "st_held";
      for (int i = 0; i < 5; i++) step(1'b1);
      idle_steps(LONG * TICK_CLKS + 5);

      phase = "async_reset";
      step(1'b1);
      idle_steps(6);
      @(negedge clk);
      #1 reset = 1'b1;
      #1 check("reset_immediate", {tif.TS, tif.TL, tif.busy}, 3'b000);
      idle_steps(2);
      #1 reset = 1'b0;
      phase = "after_reset";
      idle_steps(LONG * TICK_CLKS + 5);

      phase = "random";
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 19) == 0);
      end
      idle_steps(LONG * TICK_CLKS + 2);

      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/traffic_timer.md
# traffic_timer

Interval timer serving the traffic-light controller. The controller pulses `ST` on every light change. This block counts clock ticks from that pulse and returns the two expiry flags the controller consumes: `TS` (short interval, yellow phase) and `TL` (long interval, green phase). It sits beside the controller on the same clock and reset.

## Interface
- `SHORT_TICKS`, default 3: ticks from start until `TS` asserts; must be ≥1.
- `LONG_TICKS`, default 10: ticks from start until `TL` asserts; must be > `SHORT_TICKS`.
- `PRESCALE`, default 4: clocks per tick when prescaling is compiled in; must be ≥2.
- `Clk` input 1: single system clock, rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `ST` input 1: start/restart timer, sampled each rising edge.
- `TS` output 1: short interval expired; level, registered.
- `TL` output 1: long interval expired; level, registered.
- `busy` output 1: high while counting (state RUN).

## Operation
- Reset: state IDLE, count 0, prescaler 0, `TS`=0, `TL`=0, `busy`=0. Outputs clear immediately on reset assertion, not on the next edge.
- States and transitions:
  - IDLE: no `ST` yet → stays IDLE. `ST` → RUN.
  - RUN: counting. Count reaches `LONG_TICKS` → DONE.
  - DONE: count frozen, flags held. `ST` → RUN.
- `ST` sampled high in any state:
  - Next state RUN; count 0; prescaler 0; `TS`=0; `TL`=0.
  - `ST` has priority over a coincident tick.
- RUN: count increments by 1 per tick.
  - `TS` sets on the edge where count becomes `SHORT_TICKS`.
  - `TL` sets, and state moves to DONE, on the edge where count becomes `LONG_TICKS`.
- Flags are sticky. They stay high until the next `ST` or reset.
- `busy` = (state == RUN).
- Count width is `$clog2(LONG_TICKS+1)`. Count never exceeds `LONG_TICKS` (it freezes in DONE), so there is no wrap-around.
- `ST` held high for multiple cycles restarts the timer each cycle. Counting begins on the first edge after `ST` falls.

## Timing
- `ST` high at edge k, prescale off:
  - `TS` high from edge k+`SHORT_TICKS`.
  - `TL` high and `busy` low from edge k+`LONG_TICKS`.
- `ST` high at edge k, prescale on:
  - `TS` high from edge k+`SHORT_TICKS`·`PRESCALE`.
  - `TL` high from edge k+`LONG_TICKS`·`PRESCALE`.
- `busy`, `TS` and `TL` all change on the same edge as the `ST` sample (k).
- No combinational path from `ST` to any output.

## Configuration
- Macro `TRAFFIC_TIMER_PRESCALE_EN`.
- Defined: a tick occurs on the edge where the prescaler is at `PRESCALE`-1. The prescaler then wraps to 0; otherwise it increments. The prescaler runs only in RUN.
- Undefined: every clock in RUN is a tick. The prescaler register and the `PRESCALE` check are absent.

## Structure
- Shared package `traffic_pkg` holds:
  - State typedef `timer_state_t` {IDLE, RUN, DONE}.
  - Default constants `TRAFFIC_SHORT_TICKS`=3, `TRAFFIC_LONG_TICKS`=10, `TRAFFIC_PRESCALE`=4.
  - The light-controller state typedef.
- One sub-module, `tick_gen`: prescaler producing a one-cycle `tick` enable, with a synchronous clear driven by `ST`. Under prescale-off it reduces to `tick` = 1.

## Test plan
All scenarios use default parameters.
- Reset, then 20 clocks with `ST`=0 → `TS`=`TL`=`busy`=0 throughout.
- Prescale off, single-cycle `ST` at edge 0 → `busy` high edges 0–9; `TS` rises at edge 3; `TL` rises and `busy` falls at edge 10; flags stay high for 10 more clocks.
- Prescale on, same stimulus → `TS` rises at edge 12; `TL` rises at edge 40; no change at edges 3 or 10.
- Prescale off, `ST` at edge 0 and again at edge 5 (`TS` already high) → `TS` falls at edge 5 and rises at edge 8; `TL` rises at edge 15, not 10.
- `ST` held high for edges 0–4, then low → outputs 0 and `busy`=1 during the hold; `TS` at edge 7, `TL` at edge 14.
- Prescale off, `ST` at edge 0; `reset` asserted between edges 6 and 7 for 2 cycles, then released → `TS` drops at `reset` assertion without waiting for a clock edge; `TL` never rises; state IDLE until a new `ST`.
